// File: rtl/simon_pkg.sv
// simon_pkg: shared state encoding and size defaults for the Simon game blocks.
package simon_pkg;
  typedef enum logic [1:0] {
    S_INPUT    = 2'b00,
    S_PLAYBACK = 2'b01,
    S_REPEAT   = 2'b10,
    S_DONE     = 2'b11
  } state_t;
  localparam int MAX_LEN_DEF    = 64;
  localparam int PLAY_TICKS_DEF = 4;
endpackage

// File: rtl/simon_if.sv
// simon_if: controller-to-datapath control strobes and status flags.
interface simon_if;
  logic       next;
  logic       legal;
  logic       correct;
  logic       cont;
  logic       seq_ctr_inc;
  logic       pbrd_ctr_inc;
  logic       wr;
  logic       led;
  logic [1:0] state;
  modport master (input next, legal, correct, cont,
                  output seq_ctr_inc, pbrd_ctr_inc, wr, led, state);
  modport slave  (output next, legal, correct, cont,
                  input seq_ctr_inc, pbrd_ctr_inc, wr, led, state);
endinterface

// File: rtl/simon_tick_timer.sv
// simon_tick_timer: PLAY_TICKS modulo counter pacing playback, pulses tc_o on terminal count.
module simon_tick_timer #(
  parameter int PLAY_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = $clog2(PLAY_TICKS);
  localparam logic [W-1:0] LAST = W'(PLAY_TICKS - 1);
  logic [W-1:0] tick_q, tick_d;
  assign tc_o = en_i & (tick_q == LAST);
  always_comb tick_d = (clear_i || tc_o) ? '0 : en_i ? tick_q + 1'b1 : tick_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) tick_q <= '0;
    else     tick_q <= tick_d;
endmodule

// File: rtl/simon_controller.sv
// simon_controller: Simon game control FSM sequencing entry, memory write, playback, repeat and game over.
module simon_controller
  import simon_pkg::*;
#(
  parameter int PLAY_TICKS = PLAY_TICKS_DEF,
  parameter int MAX_LEN    = MAX_LEN_DEF
) (
  input logic      clk,
  input logic      rst,
  simon_if.master  bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic          tc, play, clear, wr, seq_inc, pbrd_inc;
  assign play  = (state_q == S_PLAYBACK) || (state_q == S_DONE);
  assign clear = (state_d != state_q) && ((state_d == S_PLAYBACK) || (state_d == S_DONE));
  simon_tick_timer #(.PLAY_TICKS(PLAY_TICKS)) u_tick (
    .clk(clk), .rst(rst), .clear_i(clear), .en_i(play), .tc_o(tc)
  );
  // Strobes are gated by rst so they drop immediately even while inputs are still active.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr       = 1'b0;
    seq_inc  = 1'b0;
    pbrd_inc = 1'b0;
    if (!rst)
      unique case (state_q)
        S_INPUT:
          if (bus.next && bus.legal) begin
            wr      = 1'b1;
            seq_inc = 1'b1;
            len_d   = len_q + 1'b1;
            state_d = S_PLAYBACK;
          end
        S_PLAYBACK:
          if (tc) begin
            pbrd_inc = 1'b1;
            state_d  = bus.cont ? S_PLAYBACK : S_REPEAT;
          end
        S_REPEAT:
          if (bus.next && bus.legal) begin
            pbrd_inc = bus.correct;
            state_d  = !bus.correct ? S_DONE :
                       bus.cont ? S_REPEAT :
                       (len_q == LW'(MAX_LEN)) ? S_DONE : S_INPUT;
          end
        S_DONE: pbrd_inc = tc;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_INPUT;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  assign bus.wr           = wr;
  assign bus.seq_ctr_inc  = seq_inc;
  assign bus.pbrd_ctr_inc = pbrd_inc;
  assign bus.led          = play;
  assign bus.state        = state_q;
endmodule
